sid_waveform_mux: RTL and testbench

- Time-multiplexed, parametrised waveform generator for VOICES SID voices. It shares one adder, one comparator and one LFSR datapath across all voices.
- Per-voice state (oscillator, noise LFSR, pulse, tri_xor, noise age) lives in internal register arrays.
- Sits between the register file and the waveform mixer/DAC. It is started once per SID cycle, at PHI2_PHI1, by the phase generator.
- Generalises the single-voice generator with:
  - configurable voice count and widths;
  - a sync/ring-mod chain across voices;
  - a start/done handshake;
  - overrun detection.

---
 rtl/sid_waveform_mux.sv | 192 +++++++++++++++++++
 tb/tb_sid_waveform_mux.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sid_waveform_mux.sv
// Time-multiplexed SID waveform generator: one adder, comparator and LFSR step shared by VOICES voices.
// A CALC pass computes every oscillator sum, then a COMMIT pass updates per-voice state in order.
package sid;
  typedef enum logic {MOS6581 = 1'b0, MOS8580 = 1'b1} model_e;
endpackage

module sid_waveform_mux #(
  parameter int unsigned VOICES         = 3,
  parameter int unsigned ACC_W          = 24,
  parameter int unsigned FREQ_W         = 16,
  parameter int unsigned PW_W           = 12,
  parameter int unsigned OUT_W          = 12,
  parameter logic [13:0] NOISE_TTL_6581 = 14'd33,
  parameter logic [13:0] NOISE_TTL_8580 = 14'd9765
) (
  input  logic                      clk,
  input  logic                      res_n,
  input  logic                      tick_ms,
  input  sid::model_e               model,
  input  logic                      start,
  input  logic [VOICES*FREQ_W-1:0]  freq,
  input  logic [VOICES*PW_W-1:0]    pw,
  input  logic [VOICES*8-1:0]       ctrl,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun,
  output logic [VOICES*4-1:0]       selector,
  output logic [VOICES*OUT_W-1:0]   saw_tri,
  output logic [VOICES-1:0]         pulse,
  output logic [VOICES*8-1:0]       noise
);
  localparam int unsigned VW     = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [VW-1:0] LAST_V = VW'(VOICES - 1);
  localparam logic [22:0] TAP_MASK = 23'h144A25;
  localparam int unsigned C_SYNC = 1, C_RING = 2, C_TEST = 3, C_SAW = 5;
  localparam int unsigned C_TRI = 4, C_PULSE = 6, C_NOISE = 7;

  function automatic logic [ACC_W-1:0] osc_init();
    logic [ACC_W-1:0] r;
    for (int unsigned i = 0; i < ACC_W; i++) r[i] = (i % 2 == 0);
    return r;
  endfunction
  localparam logic [ACC_W-1:0] OSC_INIT = osc_init();

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_COMMIT, S_DONE} state_e;

  state_e            r_state;
  logic [VW-1:0]     r_v;
  logic              r_busy, r_done, r_overrun;
  logic [ACC_W-1:0]  r_osc      [VOICES];
  logic [ACC_W-1:0]  r_osc_next [VOICES];
  logic [22:0]       r_lfsr     [VOICES];
  logic [13:0]       r_age      [VOICES];
  logic [OUT_W-1:0]  r_saw_tri  [VOICES];
  logic [3:0]        r_sel      [VOICES];
  logic [VOICES-1:0] r_msb_next, r_msb_prev, r_msb_snap, r_tri_xor, r_pulse;
  logic [VOICES-1:0] r_bit_prev, r_nres_prev, r_nclk_prev;

  logic [VW-1:0]     w_s, w_t;
  logic [ACC_W-1:0]  w_sum, w_osc_new;
  logic [OUT_W-1:0]  w_top, w_saw_tri;
  logic [22:0]       w_lfsr_new;
  logic [13:0]       w_age_new, w_ttl;
  logic              w_synced_s, w_msb_i, w_sync_res, w_tri_new, w_tx, w_pulse_new;
  logic              w_nres, w_obit, w_nclk, w_combined;

  // Sync chain reads r_msb_snap, the pre-cycle msb_prev, so voices committed
  // earlier in the pass do not leak their new msb_prev into later voices.
  always_comb begin
    w_s = (r_v == '0) ? LAST_V : r_v - 1'b1;
    w_t = (w_s == '0) ? LAST_V : w_s - 1'b1;
    w_sum = r_osc[r_v] + ACC_W'(freq[r_v*FREQ_W +: FREQ_W]);

    w_synced_s = ctrl[w_s*8 + C_TEST]
               | (ctrl[w_s*8 + C_SYNC] & ~r_msb_snap[w_s] & r_msb_next[w_t]);
    w_msb_i    = r_msb_next[w_s] & ~w_synced_s;
    w_sync_res = ctrl[r_v*8 + C_TEST]
               | (ctrl[r_v*8 + C_SYNC] & ~r_msb_snap[r_v] & w_msb_i);
    w_osc_new  = w_sync_res ? '0 : r_osc_next[r_v];
    w_tri_new  = ~ctrl[r_v*8 + C_SAW]
               & ((ctrl[r_v*8 + C_RING] & ~w_msb_i) ^ (r_msb_next[r_v] & ~w_sync_res));
    w_pulse_new = (r_osc[r_v][ACC_W-1 -: PW_W] >= pw[r_v*PW_W +: PW_W]) | ctrl[r_v*8 + C_TEST];

    // 8580 shapes from pre-commit state, which delays its output by one SID cycle.
    w_top = (model == sid::MOS8580) ? r_osc[r_v][ACC_W-1 -: OUT_W] : w_osc_new[ACC_W-1 -: OUT_W];
    w_tx  = (model == sid::MOS8580) ? r_tri_xor[r_v] : w_tri_new;
    w_saw_tri = {w_top[OUT_W-1], w_top[OUT_W-2:0] ^ {(OUT_W-1){w_tx}}};

    w_nres = ctrl[r_v*8 + C_TEST];
    w_obit = r_osc[r_v][ACC_W-5];
    w_nclk = ~(w_nres | (~r_bit_prev[r_v] & w_obit));
    w_ttl  = (model == sid::MOS8580) ? NOISE_TTL_8580 : NOISE_TTL_6581;
    w_combined = ctrl[r_v*8 + C_NOISE]
               & (ctrl[r_v*8 + C_PULSE] | ctrl[r_v*8 + C_SAW] | ctrl[r_v*8 + C_TRI]);
    w_lfsr_new = r_lfsr[r_v];
    w_age_new  = r_age[r_v];
    if (!w_nclk) begin
      if (r_age[r_v] == w_ttl) w_lfsr_new = '1;
      else                     w_age_new  = r_age[r_v] + 14'(tick_ms);
    end else begin
      w_age_new = '0;
      if (!r_nclk_prev[r_v])
        w_lfsr_new = {r_lfsr[r_v][21:0], (r_nres_prev[r_v] | r_lfsr[r_v][22]) ^ r_lfsr[r_v][17]};
      else if (w_combined)
        w_lfsr_new = r_lfsr[r_v] & ~TAP_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_state <= S_IDLE;
      r_v <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_overrun <= 1'b0;
      for (int unsigned i = 0; i < VOICES; i++) begin
        r_osc[i]      <= OSC_INIT;
        r_osc_next[i] <= '0;
        r_lfsr[i]     <= '1;
        r_age[i]      <= '0;
        r_saw_tri[i]  <= '0;
        r_sel[i]      <= '0;
      end
      r_msb_next  <= '0;
      r_msb_prev  <= '0;
      r_msb_snap  <= '0;
      r_tri_xor   <= '0;
      r_pulse     <= '0;
      r_bit_prev  <= '0;
      r_nres_prev <= '0;
      r_nclk_prev <= '1;
    end else begin
      if (start && r_state != S_IDLE) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_CALC;
          r_v <= '0;
          r_busy <= 1'b1;
          r_msb_snap <= r_msb_prev;
        end
        S_CALC: begin
          r_osc_next[r_v] <= w_sum;
          r_msb_next[r_v] <= w_sum[ACC_W-1];
          if (r_v == LAST_V) begin
            r_v <= '0;
            r_state <= S_COMMIT;
          end else r_v <= r_v + 1'b1;
        end
        S_COMMIT: begin
          r_osc[r_v]       <= w_osc_new;
          r_msb_prev[r_v]  <= w_msb_i;
          r_tri_xor[r_v]   <= w_tri_new;
          r_pulse[r_v]     <= w_pulse_new;
          r_saw_tri[r_v]   <= w_saw_tri;
          r_sel[r_v]       <= ctrl[r_v*8 + 4 +: 4];
          r_lfsr[r_v]      <= w_lfsr_new;
          r_age[r_v]       <= w_age_new;
          r_bit_prev[r_v]  <= w_obit;
          r_nres_prev[r_v] <= w_nres;
          r_nclk_prev[r_v] <= w_nclk;
          if (r_v == LAST_V) begin
            r_v <= '0;
            r_state <= S_DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else r_v <= r_v + 1'b1;
        end
        default: begin
          r_done <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;
  assign pulse   = r_pulse;

  always_comb begin
    selector = '0;
    saw_tri  = '0;
    noise    = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      selector[i*4 +: 4]        = r_sel[i];
      saw_tri[i*OUT_W +: OUT_W] = r_saw_tri[i];
      noise[i*8 +: 8] = {r_lfsr[i][20], r_lfsr[i][18], r_lfsr[i][14], r_lfsr[i][11],
                         r_lfsr[i][9],  r_lfsr[i][5],  r_lfsr[i][2],  r_lfsr[i][0]};
    end
  end
endmodule

// File: tb/tb_sid_waveform_mux.sv
// Directed bench for sid_waveform_mux (3 voices, 24-bit accumulator and frequency words).
module tb_sid_waveform_mux;
  logic        clk = 1'b0, res_n = 1'b0, tick_ms = 1'b0, start = 1'b0;
  sid::model_e model = sid::MOS6581;
  logic [71:0] freq = '0;
  logic [35:0] pw = '0;
  logic [23:0] ctrl = '0;
  logic        busy, done, overrun;
  logic [11:0] selector;
  logic [35:0] saw_tri;
  logic [2:0]  pulse;
  logic [23:0] noise;

  int n_chk = 0;
  int n_fail = 0;

  sid_waveform_mux #(
    .VOICES(3), .ACC_W(24), .FREQ_W(24), .PW_W(12), .OUT_W(12),
    .NOISE_TTL_6581(14'd33), .NOISE_TTL_8580(14'd9765)
  ) dut (
    .clk(clk), .res_n(res_n), .tick_ms(tick_ms), .model(model), .start(start),
    .freq(freq), .pw(pw), .ctrl(ctrl), .busy(busy), .done(done), .overrun(overrun),
    .selector(selector), .saw_tri(saw_tri), .pulse(pulse), .noise(noise)
  );

  always #5 clk = ~clk;

  typedef struct {
    sid::model_e model;
    logic [71:0] freq;
    logic [35:0] pw;
    logic [23:0] ctrl;
    int          ncyc;
    logic [35:0] e_st;
    logic [2:0]  e_pulse;
    logic [11:0] e_sel;
    logic [23:0] e_noise;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_n = 1'b0; start = 1'b0; tick_ms = 1'b0;
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b1;
  endtask

  task automatic run_cycle();
    int k;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 16) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: done not seen within %0d clocks", k);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, first_done;

    vecs[0] = '{sid::MOS6581, {24'h0, 24'h0, 24'h001000}, {12'h800, 12'h800, 12'h800},
                {8'h00, 8'h00, 8'h20}, 1, 36'h555555556, 3'b000, 12'h002, 24'hFFFFFF};
    vecs[1] = '{sid::MOS6581, {24'h800000, 24'h0, 24'h001000}, 36'h0,
                {8'h20, 8'h00, 8'h22}, 1, 36'hD55555000, 3'b111, 12'h202, 24'hFFFFFF};
    vecs[2] = '{sid::MOS6581, {24'h800000, 24'h0, 24'h001000}, {12'hD56, 12'h556, 12'h555},
                {8'h20, 8'h00, 8'h14}, 2, 36'h5555552A8, 3'b001, 12'h201, 24'hFFFFFF};
    vecs[3] = '{sid::MOS6581, {24'h800000, 24'h800000, 24'h800000}, {12'h555, 12'hFFF, 12'h000},
                {8'h22, 8'h22, 8'h22}, 1, 36'hD55D55D55, 3'b101, 12'h222, 24'hFFFFFF};
    vecs[4] = '{sid::MOS8580, {24'h0, 24'h0, 24'h001000}, {12'h800, 12'h800, 12'h800},
                {8'h00, 8'h00, 8'h20}, 1, 36'h555555555, 3'b000, 12'h002, 24'hFFFFFF};
    vecs[5] = '{sid::MOS8580, {24'h0, 24'h0, 24'h001000}, {12'h800, 12'h800, 12'h800},
                {8'h00, 8'h00, 8'h20}, 2, 36'h555555556, 3'b000, 12'h002, 24'hFFFFFF};
    vecs[6] = '{sid::MOS6581, {24'h0, 24'h001000, 24'h0}, {12'hFFF, 12'hFFF, 12'hFFF},
                {8'h00, 8'h28, 8'h00}, 1, 36'h555000555, 3'b010, 12'h020, 24'hFFFFFF};

    do_reset();
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_saw_tri", saw_tri, 36'h0);
    check("rst_selector", selector, 12'h0);
    check("rst_pulse", pulse, 3'b0);
    check("rst_noise", noise, 24'hFFFFFF);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      model = vecs[i].model; freq = vecs[i].freq; pw = vecs[i].pw; ctrl = vecs[i].ctrl;
      for (int c = 0; c < vecs[i].ncyc; c++) run_cycle();
      check($sformatf("vec%0d_saw_tri", i), saw_tri, vecs[i].e_st);
      check($sformatf("vec%0d_pulse", i), pulse, vecs[i].e_pulse);
      check($sformatf("vec%0d_selector", i), selector, vecs[i].e_sel);
      check($sformatf("vec%0d_noise", i), noise, vecs[i].e_noise);
    end

    // latency, busy width and ignored second start
    do_reset();
    model = sid::MOS6581; freq = {24'h0, 24'h0, 24'h001000};
    pw = {3{12'h800}}; ctrl = {8'h00, 8'h00, 8'h20};
    busy_cnt = 0; done_cnt = 0; first_done = 0;
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
      end
    end
    check("latency", first_done, 7);
    check("busy_clocks", busy_cnt, 6);
    check("done_count", done_cnt, 1);
    check("overrun_set", overrun, 1'b1);
    check("overrun_saw0", saw_tri[11:0], 12'h556);
    run_cycle();
    check("overrun_sticky", overrun, 1'b1);
    check("second_cycle_saw0", saw_tri[11:0], 12'h557);

    // reset in the middle of COMMIT
    do_reset();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_commit_busy", busy, 1'b1);
    check("mid_commit_saw_tri", saw_tri, 36'h000000556);
    res_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_saw_tri", saw_tri, 36'h0);
    check("abort_selector", selector, 12'h0);
    res_n = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    // reset wins over a simultaneous start
    @(negedge clk);
    res_n = 1'b0; start = 1'b1;
    @(negedge clk);
    check("reset_vs_start_busy", busy, 1'b0);
    res_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("reset_vs_start_idle", busy, 1'b0);

    // noise: combined-waveform clear, TTL refill under test, shift on test release
    do_reset();
    model = sid::MOS6581; freq = '0; pw = '0; ctrl = {8'h00, 8'hC0, 8'h00};
    run_cycle();
    check("noise_comb_clear", noise, 24'hFF00FF);
    ctrl = {8'h00, 8'hC8, 8'h00};
    tick_ms = 1'b1;
    repeat (33) run_cycle();
    check("noise_before_ttl", noise, 24'hFF00FF);
    check("test_pulse1", pulse[1], 1'b1);
    check("test_osc1_zero", saw_tri[23:12], 12'h000);
    tick_ms = 1'b0;
    run_cycle();
    check("noise_ttl_refill", noise, 24'hFFFFFF);
    ctrl = {8'h00, 8'h80, 8'h00};
    run_cycle();
    check("noise_release_shift", noise, 24'hFFFEFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
